el2_trace_capture: RTL and testbench
====================================

# el2_trace_capture

Trace capture buffer downstream of the core's `el2_trace_pkt_t` retirement trace output. It captures every valid retired-instruction trace packet into a DEPTH-entry FIFO and presents entries on a valid/ready drain port for a debug or trace-export unit. The core cannot be stalled, so overflow drops the newest packet, counts the drop, and flags the next accepted entry.

## Interface
Parameters:
- `DEPTH`, 8: number of FIFO entries; power of two, at least 2.
- `CW`, `$clog2(DEPTH)+1`: width of the occupancy count (derived).

Ports:
- `clk` in 1: core clock.
- `rst_l` in 1: reset, asynchronous, active-low.
- `trace_in` in `el2_trace_pkt_t` (104 bits): retirement trace; push qualifier is `trace_rv_i_valid_ip`.
- `capture_en` in 1: 0 ignores all incoming packets. Stored entries still drain.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_pkt` out `el2_trace_pkt_t`: head packet; all zeros when `out_valid`=0.
- `out_ovf` out 1: one or more packets were dropped immediately before this entry; 0 when `out_valid`=0.
- `out_ts` out 32: capture timestamp of the head entry. Present only with the macro.
- `drop_cnt` out 16: saturating count of dropped packets.
- `drop_clr` in 1: synchronous clear of `drop_cnt`.
- `level` out CW: current occupancy, 0..DEPTH.

## Operation
- push = `capture_en & trace_in.trace_rv_i_valid_ip`. pop = `out_valid & out_ready`.
- Accept: push when not full, or when full with a simultaneous pop. The freed slot is reused in the same cycle, so there is no drop.
- Drop: push when full and no pop.
  - `drop_cnt` increments and saturates at 16'hFFFF.
  - `ovf_pending` is set.
- On accept, the entry stores `{ovf_pending, [ts], trace_in}`, and `ovf_pending` clears in the same cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` tracks push minus pop and holds on a simultaneous push and pop.
- `drop_clr`:
  - `drop_cnt` goes to 0 next cycle.
  - If a drop coincides, `drop_cnt` goes to 1.
  - `ovf_pending` is unaffected.
- Pop from empty is impossible, because `out_valid`=0.
- `capture_en` falling mid-stream causes no flush. Draining continues.
- Reset value of every output is 0. `rst_l` asserted mid-operation discards all entries, `ovf_pending`, and `drop_cnt` asynchronously.

## Timing
- Push to `out_valid`: 1 cycle, registered. There is no bypass, even when empty.
- `out_pkt`, `out_ovf`, and `out_ts` are held stable while `out_valid & !out_ready`.
- A pop in cycle N presents the next entry, or `out_valid`=0, in cycle N+1.
- `level` and `drop_cnt` are registered and update the cycle after the event.
- Full sustained throughput is 1 push and 1 pop per cycle.

## Configuration
- `EL2_TRACE_CAPTURE_TS_EN` defined:
  - A free-running 32-bit cycle counter resets to 0 and increments every cycle, wrapping 32'hFFFFFFFF to 0.
  - Its value in the push cycle is stored per entry and output on `out_ts`, which is 0 when `out_valid`=0.
- Undefined: no counter, no timestamp storage, and no `out_ts` port.

## Structure
- Shared package `el2_pkg`:
  - `el2_trace_cap_entry_t` with `{ovf, ts (macro-guarded), el2_trace_pkt_t pkt}`.
  - `localparam EL2_TRACE_DROP_CW = 16`.
- One sub-module, `el2_trace_capture_fifo`: generic DEPTH×width storage with pointers, `level`, and full/empty. Storage is not reset; zero-masking of outputs sits in the top.
- The top holds the push/drop decision, `ovf_pending`, `drop_cnt`, and the timestamp counter.

## Test plan
- Reset, then 3 pushes with `out_ready`=0 → `level`=3, `out_valid`=1 from the cycle after the first push, and `out_pkt` equals the first packet held stable. Raise `out_ready` → packets drain in order over 3 cycles, then `out_valid`=0.
- DEPTH=8: 10 pushes, no pops → entries 1–8 stored, `drop_cnt`=2, `level`=8. Pop 1, then push 1 → the new entry has `out_ovf`=1 and earlier entries have `out_ovf`=0.
- Full FIFO with a simultaneous push and pop for 20 cycles → `drop_cnt`=0, `level` stays 8, and order is preserved across pointer wrap.
- `capture_en`=0 with valid trace for 5 cycles → `level`=0, `drop_cnt`=0. Preload `drop_cnt`=16'hFFFF via overflow, drop once more → stays 16'hFFFF. `drop_clr` together with a drop → `drop_cnt`=1.
- `rst_l` asserted with `level`=5 and `drop_cnt`=3 → all outputs 0 immediately. First push after release shows `out_ovf`=0.
- With `EL2_TRACE_CAPTURE_TS_EN`: pushes at cycles 10 and 13 after reset → `out_ts`=10 then 13. Force the counter to 32'hFFFFFFFF and push on consecutive cycles → `out_ts`=32'hFFFFFFFF then 0.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared EL2 types for the trace capture buffer: retirement trace packet and stored entry.
// Optional EL2_TRACE_CAPTURE_TS_EN adds a 32-bit capture timestamp to each entry.
package el2_pkg;

    localparam int unsigned EL2_TRACE_DROP_CW = 16;
    localparam int unsigned EL2_TRACE_TS_W    = 32;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

    // ovf marks that packets were lost just before this entry was captured
    typedef struct packed {
        logic                      ovf;
`ifdef EL2_TRACE_CAPTURE_TS_EN
        logic [EL2_TRACE_TS_W-1:0] ts;
`endif
        el2_trace_pkt_t            pkt;
    } el2_trace_cap_entry_t;

endpackage

// File: rtl/el2_trace_capture_fifo.sv
// Generic DEPTH x W FIFO with wrapping pointers, registered occupancy and full/empty flags.
// Storage is not reset; callers must never push when full without a simultaneous pop.
module el2_trace_capture_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + LW'(1);
            end else if (i_pop && !i_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/el2_trace_capture.sv
// Trace capture buffer: stores retired-instruction trace packets, drops newest on overflow.
// Define EL2_TRACE_CAPTURE_TS_EN to add a free-running cycle timestamp per entry (out_ts).
module el2_trace_capture
    import el2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  el2_trace_pkt_t               trace_in,
    input  logic                         capture_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output el2_trace_pkt_t               out_pkt,
    output logic                         out_ovf,
`ifdef EL2_TRACE_CAPTURE_TS_EN
    output logic [EL2_TRACE_TS_W-1:0]    out_ts,
`endif
    output logic [EL2_TRACE_DROP_CW-1:0] drop_cnt,
    input  logic                         drop_clr,
    output logic [CW-1:0]                level
);

    localparam int unsigned EW = $bits(el2_trace_cap_entry_t);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic                         w_push;
    logic                         w_pop;
    logic                         w_accept;
    logic                         w_drop;
    logic                         w_full;
    logic                         w_empty;
    logic [LW-1:0]                w_level;
    logic [EW-1:0]                w_wdata;
    logic [EW-1:0]                w_rdata;
    el2_trace_cap_entry_t         w_wentry;
    el2_trace_cap_entry_t         w_rentry;
    logic                         r_ovf_pending;
    logic [EL2_TRACE_DROP_CW-1:0] r_drop_cnt;

    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_push   = capture_en & trace_in.trace_rv_i_valid_ip;
    assign w_pop    = out_valid & out_ready;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

`ifdef EL2_TRACE_CAPTURE_TS_EN
    logic [EL2_TRACE_TS_W-1:0] r_ts_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + EL2_TRACE_TS_W'(1);
        end
    end
`endif

    always_comb begin
        w_wentry     = '0;
        w_wentry.ovf = r_ovf_pending;
`ifdef EL2_TRACE_CAPTURE_TS_EN
        w_wentry.ts  = r_ts_cnt;
`endif
        w_wentry.pkt = trace_in;
    end

    assign w_wdata  = w_wentry;
    assign w_rentry = w_rdata;

    el2_trace_capture_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Overflow flag rides on the next accepted entry, then clears
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ovf_pending <= 1'b0;
        end else if (w_accept) begin
            r_ovf_pending <= 1'b0;
        end else if (w_drop) begin
            r_ovf_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_drop_cnt <= '0;
        end else if (drop_clr) begin
            r_drop_cnt <= w_drop ? EL2_TRACE_DROP_CW'(1) : '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + EL2_TRACE_DROP_CW'(1);
        end
    end

    assign out_valid = ~w_empty;
    assign out_pkt   = out_valid ? w_rentry.pkt : '0;
    assign out_ovf   = out_valid & w_rentry.ovf;
`ifdef EL2_TRACE_CAPTURE_TS_EN
    assign out_ts    = out_valid ? w_rentry.ts : '0;
`endif
    assign drop_cnt  = r_drop_cnt;
    assign level     = CW'(w_level);

endmodule

// File: tb/tb_el2_trace_capture.sv
// Scoreboard bench for el2_trace_capture: random and directed traffic against a queue model.
// Timestamps are checked when EL2_TRACE_CAPTURE_TS_EN is defined.
module tb_el2_trace_capture;
    import el2_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic           ovf;
        logic [31:0]    ts;
        el2_trace_pkt_t pkt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    el2_trace_pkt_t trace_in = '0;
    logic           capture_en = 1'b0;
    logic           out_ready = 1'b0;
    logic           drop_clr = 1'b0;
    logic           out_valid;
    el2_trace_pkt_t out_pkt;
    logic           out_ovf;
    logic [15:0]    drop_cnt;
    logic [CW-1:0]  level;
`ifdef EL2_TRACE_CAPTURE_TS_EN
    logic [31:0]    out_ts;
`endif

    el2_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .trace_in   (trace_in),
        .capture_en (capture_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pkt    (out_pkt),
        .out_ovf    (out_ovf),
`ifdef EL2_TRACE_CAPTURE_TS_EN
        .out_ts     (out_ts),
`endif
        .drop_cnt   (drop_cnt),
        .drop_clr   (drop_clr),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Reference model state, committed after each active edge
    exp_t        exp_q[$];
    int          m_level = 0;
    int unsigned m_drop = 0;
    bit          m_ovf_pending = 1'b0;
    logic [31:0] m_cycle = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic el2_trace_pkt_t rand_pkt(input logic v);
        logic [127:0]   r;
        el2_trace_pkt_t p;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        p = r[103:0];
        p.trace_rv_i_valid_ip = v;
        return p;
    endfunction

    // One clock of stimulus; expectations follow the buffer's push/drop rules
    task automatic step(input logic v, input logic en, input logic rdy, input logic clr);
        el2_trace_pkt_t p;
        bit             push, pop, acc, drp;
        exp_t           e;
        int unsigned    nd;
        p = rand_pkt(v);
        trace_in   = p;
        capture_en = en;
        out_ready  = rdy;
        drop_clr   = clr;
        push = en && v;
        pop  = (m_level > 0) && rdy;
        acc  = push && ((m_level < DEPTH) || pop);
        drp  = push && !acc;
        if (clr)                        nd = drp ? 1 : 0;
        else if (drp && m_drop < 65535) nd = m_drop + 1;
        else                            nd = m_drop;
        e.ovf = m_ovf_pending;
        e.ts  = m_cycle;
        e.pkt = p;
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
        m_drop  = nd;
        if (acc)      m_ovf_pending = 1'b0;
        else if (drp) m_ovf_pending = 1'b1;
        m_cycle = m_cycle + 32'd1;
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0;
        m_drop = 0;
        m_ovf_pending = 1'b0;
        m_cycle = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_pkt"},   128'(out_pkt),   128'(0));
        chk({tag, "_ovf"},   128'(out_ovf),   128'(0));
        chk({tag, "_level"}, 128'(level),     128'(0));
        chk({tag, "_drop"},  128'(drop_cnt),  128'(0));
`ifdef EL2_TRACE_CAPTURE_TS_EN
        chk({tag, "_ts"},    128'(out_ts),    128'(0));
`endif
    endtask

    // Monitor: compares the presented head against the scoreboard, pops on handshake
    always @(negedge clk) begin
        if (rst_l) begin
            chk("mon_valid", 128'(out_valid), 128'(m_level != 0));
            chk("mon_level", 128'(level), 128'(m_level));
            chk("mon_drop",  128'(drop_cnt), 128'(m_drop));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_entry", 128'(1), 128'(0));
                end else begin
                    chk("mon_pkt", 128'(out_pkt), 128'(exp_q[0].pkt));
                    chk("mon_ovf", 128'(out_ovf), 128'(exp_q[0].ovf));
`ifdef EL2_TRACE_CAPTURE_TS_EN
                    chk("mon_ts", 128'(out_ts), 128'(exp_q[0].ts));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("mon_idle_pkt", 128'(out_pkt), 128'(0));
                chk("mon_idle_ovf", 128'(out_ovf), 128'(0));
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_l = 1'b1;

        // Three pushes while stalled, then drain in order
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_level", 128'(level), 128'(3));
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        chk("drained_valid", 128'(out_valid), 128'(0));

        // Overflow by two, then the next accepted entry carries the flag
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        chk("ovf_drop", 128'(drop_cnt), 128'(2));
        chk("ovf_level", 128'(level), 128'(8));
        step(0, 1, 1, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        step(0, 1, 0, 1);

        // Full FIFO with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0);
        chk("stream_drop", 128'(drop_cnt), 128'(0));
        chk("stream_level", 128'(level), 128'(8));
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0);

        // Capture disabled ignores valid trace
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("dis_level", 128'(level), 128'(0));
        chk("dis_drop", 128'(drop_cnt), 128'(0));

        // Saturation and clear coinciding with a drop
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 65535; i++) step(1, 1, 0, 0);
        chk("sat_reach", 128'(drop_cnt), 128'(16'hFFFF));
        step(1, 1, 0, 0);
        chk("sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
        step(1, 1, 0, 1);
        chk("clr_with_drop", 128'(drop_cnt), 128'(1));
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0);
        step(0, 1, 0, 1);

        // Asynchronous reset with level 5 and drop_cnt 3
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        chk("pre_rst_level", 128'(level), 128'(5));
        chk("pre_rst_drop", 128'(drop_cnt), 128'(3));
        #1;
        rst_l = 1'b0;
        model_reset();
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        rst_l = 1'b1;
        step(1, 1, 0, 0);
        chk("post_rst_ovf", 128'(out_ovf), 128'(0));
        step(0, 1, 1, 0);

        // Timestamped pushes at cycles 10 and 13 after release
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);

        // Randomized traffic with varying backpressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 800; i++) begin
                step(logic'($urandom_range(0, 3) != 0),
                     logic'($urandom_range(0, 9) != 0),
                     logic'($urandom_range(0, 3) < ph + 1),
                     logic'($urandom_range(0, 63) == 0));
            end
        end
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        chk("final_empty", 128'(out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
